alu_sequencer: RTL and testbench
================================

# alu_sequencer

Fetch/decode/execute controller for the 16-bit GPR arithmetic/logic datapath. It fetches 32-bit instructions from an external instruction memory over a req/valid handshake and holds each in the instruction register presented to the datapath. It issues a one-cycle commit strobe per executed instruction, stretches multi-cycle multiplies, and stops on a HALT opcode. It sits between the instruction memory and the combinational ALU/register-file block.

## Interface
- PC_W, 8, program counter / instruction address width
- MUL_CYCLES, 3, EXEC-state cycles for opcode mul (5'b00100); legal range 1..15
- clk  input  1  system clock; all state updates on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- start  input  1  begin execution at address 0; sampled only in IDLE or HALT
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_W  fetch address, always equal to pc
- imem_valid  input  1  fetch data valid; ignored while imem_req=0
- imem_data  input  32  fetched instruction
- ir  output  32  instruction register driven to datapath (oper_type = ir[31:27])
- exec_en  output  1  one-cycle commit strobe; datapath writes GPR/SGPR only when high
- pc  output  PC_W  current program counter
- busy  output  1  high in FETCH, DECODE, EXEC
- halted  output  1  high in HALT
- retired  output  16  count of committed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset values: state IDLE, pc=0, ir=0, imem_req=0, exec_en=0, busy=0, halted=0, retired=0, exec counter=0.
- IDLE: start=1 -> FETCH, pc=0.
- FETCH: imem_req=1, imem_addr=pc.
  - Stay in FETCH until imem_valid=1.
  - On that edge: ir<=imem_data, state -> DECODE.
  - imem_addr stays stable while waiting.
- DECODE: classify ir[31:27].
  - 5'b00000..5'b01011 (movsgpr..rnot) -> EXEC. Load the exec counter with MUL_CYCLES-1 for mul, else 0.
  - 5'b11111 (HALT) -> HALT. No exec_en; pc unchanged (points at the HALT word).
  - 5'b01100..5'b11110 (undefined) -> treated as NOP: pc<=pc+1, no exec_en, retired unchanged, -> FETCH.
- EXEC: exec counter decrements each cycle.
  - When the counter is 0: exec_en=1 for that cycle, pc<=pc+1, retired<=retired+1, -> FETCH.
  - ir is held constant throughout EXEC.
- HALT: halted=1. start=1 -> pc=0, halted=0, -> FETCH (restart). No other exit.
- Width rules:
  - pc wraps from 2^PC_W-1 to 0 modulo 2^PC_W, with no halt.
  - retired wraps from 16'hFFFF to 0.
- start while busy is ignored.
- imem_valid in any state other than FETCH is ignored; ir is not updated.
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - An in-flight fetch is abandoned; imem_req drops in the same cycle.
  - An EXEC in progress produces no exec_en.
- exec_en, busy and halted are decoded from registered state only; no combinational path from inputs.

## Timing
- Cycle 0 = cycle in which start is sampled high in IDLE.
- Zero-wait memory (imem_valid=1 whenever imem_req=1):
  - FETCH cycle 1, DECODE cycle 2, EXEC cycle 3 with exec_en=1, next FETCH cycle 4.
  - Non-mul throughput: 3 cycles per instruction.
- mul: EXEC occupies MUL_CYCLES cycles; exec_en only in the last. Total 2+MUL_CYCLES cycles.
- Each cycle of imem_valid delay adds one FETCH cycle.
- NOP: 2 cycles (FETCH, DECODE).
- HALT: halted=1 starting two cycles after the HALT word's FETCH cycle completes.
- ir changes only on the edge leaving FETCH; it is stable for at least DECODE+EXEC.
- pc increments on the edge ending the last EXEC cycle (or the DECODE cycle of a NOP). The pc output during exec_en is the address of the committing instruction.

## Test plan
- Reset: assert sys_rst mid-run. Required in the same cycle: imem_req=0, exec_en=0, busy=0, halted=0, pc=0, ir=0, retired=0. After release, state stays IDLE until start.
- Zero-wait program {mov r1,#5; add r2,r1,#3; HALT} at addresses 0..2, start at cycle 0. Required: exec_en in cycles 3 and 6 only; halted=1 from cycle 9; pc=2; retired=2.
- MUL_CYCLES=3, program {mul r3,r1,r2; HALT}. Required: EXEC cycles 3–5, exec_en only in cycle 5, pc=1 in cycle 6.
- Wait states: imem_valid asserted 4 cycles after imem_req. Required: imem_req held 5 cycles; imem_addr constant; ir unchanged until the valid edge.
- Undefined opcode 5'b01100 at address 0, then HALT. Required: no exec_en; pc=1 after 2 cycles; retired=0; halted=1.
- PC_W=2 with no HALT in addresses 0..3 (all add). Required: imem_addr sequence 0,1,2,3,0; retired increments each instruction. Also: sys_rst during a mul EXEC produces no exec_en, and start then refetches address 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for the 16-bit GPR ALU datapath.
// Fetches 32-bit instructions over a req/valid handshake and holds each one in ir.
// Issues a one-cycle exec_en commit strobe per executed instruction.
// Stretches mul across MUL_CYCLES execute cycles and stops on a HALT opcode.
module alu_sequencer #(
  parameter int PC_W       = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [4:0] OP_MUL      = 5'b00100;
  localparam logic [4:0] OP_LAST_DEF = 5'b01011;
  localparam logic [4:0] OP_HALT     = 5'b11111;
  // Counter preload for mul: the counter runs down to 0 and the commit happens at 0.
  localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [4:0]  opcode;
  logic        is_defined;
  logic        is_halt;
  logic        cnt_zero;

  assign opcode     = ir[31:27];
  assign is_defined = (opcode <= OP_LAST_DEF);
  assign is_halt    = (opcode == OP_HALT);
  assign cnt_zero   = (cnt == 4'd0);

  // All status outputs come from registered state only, so no input reaches them combinationally.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign exec_en   = (state == EXEC) && cnt_zero;
  assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted    = (state == HALT);

  // State register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode. start is only looked at in IDLE or HALT, imem_valid only in FETCH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (imem_valid) state_nxt = DECODE;
      DECODE: begin
        if (is_halt)         state_nxt = HALT;
        else if (is_defined) state_nxt = EXEC;
        else                 state_nxt = FETCH;
      end
      EXEC:    if (cnt_zero) state_nxt = FETCH;
      HALT:    if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction register, program counter, execute counter and retire counter.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      pc      <= '0;
      ir      <= '0;
      cnt     <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: if (start) pc <= '0;
        FETCH: if (imem_valid) ir <= imem_data;
        DECODE: begin
          if (is_defined) begin
            cnt <= (opcode == OP_MUL) ? MUL_LOAD : 4'd0;
          end else if (!is_halt) begin
            // Undefined opcode: skip it without committing; pc stays on a HALT word.
            pc <= pc + PC_W'(1);
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            pc      <= pc + PC_W'(1);
            retired <= retired + 16'd1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HALT: if (start) pc <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against a
// cycle-cost model that derives commit times from instruction classes.
module tb_alu_sequencer;

  localparam int PC_W = 8;
  localparam int MULC = 3;
  localparam int MAXC = 400;
  localparam logic [31:0] HALTW = {5'b11111, 27'h0ABCDE};
  localparam logic [31:0] MOVW  = {5'b00001, 27'h0000105};
  localparam logic [31:0] ADDW  = {5'b00010, 27'h0000213};
  localparam logic [31:0] MULW  = {5'b00100, 27'h0000312};
  localparam logic [31:0] UNDW  = {5'b01100, 27'h0000777};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (PC_W=8)
  logic            sys_rst, start, imem_req, imem_valid, exec_en, busy, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     imem_data, ir;
  logic [15:0]     retired;

  logic [31:0] mem [256];
  int          wait_n = 0;
  logic        junk_valid;
  int          req_age = 0;

  // Memory model: valid after wait_n cycles of request; stray valid pulses outside a fetch.
  always @(posedge clk) begin
    if (!imem_req) req_age <= 0;
    else           req_age <= req_age + 1;
  end
  assign imem_valid = imem_req ? (req_age >= wait_n) : junk_valid;
  assign imem_data  = imem_req ? mem[imem_addr] : 32'hDEAD_BEEF;

  alu_sequencer #(.PC_W(PC_W), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_data(imem_data), .ir(ir), .exec_en(exec_en), .pc(pc),
    .busy(busy), .halted(halted), .retired(retired)
  );

  // Narrow instance (PC_W=2) fed with adds only
  logic        rst2, start2, req2, valid2, en2, busy2, halted2;
  logic [1:0]  addr2, pc2;
  logic [31:0] data2, ir2;
  logic [15:0] ret2;

  assign valid2 = req2;
  assign data2  = {5'b00010, 25'd0, addr2};

  alu_sequencer #(.PC_W(2), .MUL_CYCLES(MULC)) dut2 (
    .clk(clk), .sys_rst(rst2), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_valid(valid2),
    .imem_data(data2), .ir(ir2), .exec_en(en2), .pc(pc2),
    .busy(busy2), .halted(halted2), .retired(ret2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Per-cycle trace of the main instance during a program run
  logic            tr_en   [MAXC];
  logic            tr_req  [MAXC];
  logic            tr_busy [MAXC];
  logic [PC_W-1:0] tr_pc   [MAXC];
  logic [PC_W-1:0] tr_addr [MAXC];
  logic [31:0]     tr_ir   [MAXC];
  int              cyc;
  int              halt_cyc;
  int              idle_busy;
  int              got_c[$];
  logic [15:0]     exp_retired;

  // Model outputs
  int              exp_c[$];
  logic [PC_W-1:0] exp_cpc[$];
  int              exp_halt;
  logic [PC_W-1:0] exp_pc_end;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cost model: fetch 1+wait cycles, decode 1, then exec 1 (MULC for mul),
  // nothing for undefined opcodes, HALT visible the cycle after its decode.
  task automatic model(input int wn);
    int t;
    int d;
    int len;
    logic [4:0] op;
    logic [PC_W-1:0] p;
    exp_c.delete();
    exp_cpc.delete();
    t = 1;
    p = '0;
    exp_halt = -1;
    exp_pc_end = '0;
    for (int guard = 0; guard < 200 && exp_halt < 0; guard++) begin
      d  = t + wn + 1;
      op = mem[p][31:27];
      if (op == 5'd31) begin
        exp_halt   = d + 1;
        exp_pc_end = p;
      end else if (op <= 5'd11) begin
        len = (op == 5'd4) ? MULC : 1;
        exp_c.push_back(d + len);
        exp_cpc.push_back(p);
        p = p + PC_W'(1);
        t = d + len + 1;
      end else begin
        p = p + PC_W'(1);
        t = d + 1;
      end
    end
  endtask

  // Start the main instance (from IDLE or HALT) and trace it until halted or the bound.
  task automatic run_prog(input int limit);
    got_c.delete();
    halt_cyc  = -1;
    idle_busy = 0;
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
    while (halt_cyc < 0 && cyc < limit) begin
      tr_en[cyc]   = exec_en;
      tr_req[cyc]  = imem_req;
      tr_busy[cyc] = busy;
      tr_pc[cyc]   = pc;
      tr_addr[cyc] = imem_addr;
      tr_ir[cyc]   = ir;
      if (exec_en) got_c.push_back(cyc);
      if (halted) halt_cyc = cyc;
      else begin
        if (!busy) idle_busy++;
        step();
      end
    end
    check("halt_reached", 32'(halt_cyc >= 0), 32'd1);
  endtask

  task automatic compare_run(input string name);
    check({name, "_n_commits"}, got_c.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
      check({name, "_commit_cyc"}, got_c[i], exp_c[i]);
      check({name, "_commit_pc"}, 32'(tr_pc[got_c[i]]), 32'(exp_cpc[i]));
      check({name, "_commit_ir"}, tr_ir[got_c[i]], mem[exp_cpc[i]]);
    end
    check({name, "_halt_cyc"}, halt_cyc, exp_halt);
    check({name, "_halt_pc"}, 32'(pc), 32'(exp_pc_end));
    check({name, "_retired"}, 32'(retired), 32'(exp_retired));
    check({name, "_busy_gaps"}, idle_busy, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALTW;
  endtask

  initial begin
    int n;
    int k;
    logic prev_req2;
    int fa[$];
    sys_rst = 1'b1; start = 1'b0; junk_valid = 1'b0;
    rst2 = 1'b1; start2 = 1'b0;
    exp_retired = '0;
    cyc = 0;
    clear_mem();

    // Reset state
    step(); step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_en", 32'(exec_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    sys_rst = 1'b0;
    step(); step(); step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_halted", 32'(halted), 32'd0);

    // mov; add; HALT with zero-wait memory and stray valid pulses outside fetches
    junk_valid = 1'b1;
    mem[0] = MOVW; mem[1] = ADDW; mem[2] = HALTW;
    wait_n = 0;
    model(0);
    run_prog(60);
    exp_retired = exp_retired + 16'd2;
    compare_run("prog3");
    check("prog3_en_a", 32'(got_c.size() > 0 ? got_c[0] : -1), 32'd3);
    check("prog3_en_b", 32'(got_c.size() > 1 ? got_c[1] : -1), 32'd6);
    check("prog3_halt", halt_cyc, 9);
    check("prog3_pc", 32'(pc), 32'd2);
    check("prog3_ret", 32'(retired), 32'd2);

    // mul; HALT restarted from HALT
    clear_mem();
    mem[0] = MULW; mem[1] = HALTW;
    model(0);
    run_prog(60);
    exp_retired = exp_retired + 16'd1;
    compare_run("mul");
    for (int c = 3; c <= 5; c++) begin
      check("mul_exec_busy", 32'(tr_busy[c]), 32'd1);
      check("mul_exec_noreq", 32'(tr_req[c]), 32'd0);
      check("mul_ir_hold", tr_ir[c], MULW);
      check("mul_en", 32'(tr_en[c]), (c == 5) ? 32'd1 : 32'd0);
    end
    check("mul_pc6", 32'(tr_pc[6]), 32'd1);
    check("mul_fetch6", 32'(tr_req[6]), 32'd1);

    // Four wait states on every fetch
    clear_mem();
    mem[0] = ADDW; mem[1] = HALTW;
    wait_n = 4;
    model(4);
    run_prog(80);
    exp_retired = exp_retired + 16'd1;
    compare_run("wait");
    for (int c = 1; c <= 5; c++) begin
      check("wait_req", 32'(tr_req[c]), 32'd1);
      check("wait_addr", 32'(tr_addr[c]), 32'd0);
      check("wait_ir_old", tr_ir[c], HALTW);
    end
    check("wait_req_drop", 32'(tr_req[6]), 32'd0);
    check("wait_ir_new", tr_ir[6], ADDW);
    wait_n = 0;

    // Undefined opcode behaves as a NOP
    clear_mem();
    mem[0] = UNDW; mem[1] = HALTW;
    model(0);
    run_prog(40);
    compare_run("nop");
    check("nop_pc3", 32'(tr_pc[3]), 32'd1);
    check("nop_halt", halt_cyc, 5);

    // Randomized programs with random wait states
    for (int r = 0; r < 6; r++) begin
      clear_mem();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        mem[i] = {5'($urandom_range(0, 30)), 27'($urandom)};
      end
      wait_n = $urandom_range(0, 3);
      model(wait_n);
      run_prog(MAXC - 1);
      exp_retired = exp_retired + 16'(exp_c.size());
      compare_run("rand");
    end
    wait_n = 0;

    // Reset in the middle of a mul execute
    clear_mem();
    mem[0] = MULW; mem[1] = HALTW;
    start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    step(); step(); step();
    check("mrst_pre_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    #1;
    exp_retired = '0;
    check("mrst_req", 32'(imem_req), 32'd0);
    check("mrst_en", 32'(exec_en), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_halted", 32'(halted), 32'd0);
    check("mrst_pc", 32'(pc), 32'd0);
    check("mrst_ir", ir, 32'd0);
    check("mrst_retired", 32'(retired), 32'd0);
    step();
    check("mrst_en_hold", 32'(exec_en), 32'd0);
    step();
    sys_rst = 1'b0;
    step(); step();
    check("mrst_idle", 32'(busy), 32'd0);
    start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    check("mrst_refetch_req", 32'(imem_req), 32'd1);
    check("mrst_refetch_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 8; i++) step();
    check("mrst_rerun_halted", 32'(halted), 32'd1);
    check("mrst_rerun_ret", 32'(retired), 32'd1);
    check("mrst_rerun_pc", 32'(pc), 32'd1);

    // PC_W=2 wraparound with no HALT
    rst2 = 1'b0;
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    prev_req2 = 1'b0;
    k = 0;
    for (int c = 1; c <= 16; c++) begin
      if (req2 && !prev_req2) fa.push_back(int'(addr2));
      prev_req2 = req2;
      if (en2) begin
        check("w2_ret_before", 32'(ret2), 32'(k));
        check("w2_commit_pc", 32'(pc2), 32'(k % 4));
        k++;
      end
      step();
    end
    check("w2_commits", k, 5);
    check("w2_ret", 32'(ret2), 32'd5);
    check("w2_nfetch", 32'(fa.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < fa.size(); i++) begin
      check("w2_fetch_addr", fa[i], i % 4);
    end
    check("w2_not_halted", 32'(halted2), 32'd0);
    rst2 = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
